// File: rtl/cpu_ocimem_monitor.sv
// Nios II OCI monitor memory: a 256x32 RAM shared between JTAG debug commands
// (auto-incrementing MonAReg) and a CPU-side Avalon slave; debug always wins.
module cpu_ocimem_monitor (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  input  logic [7:0]  cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DBG_RD,
    ST_CPU_RD
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        pend_q, pend_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  mon_a_q, mon_a_d;
  logic [31:0] mon_d_q, mon_d_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;

  logic [31:0] mem [256];
  logic [31:0] ram_q;
  logic [31:0] rd_word;
  logic [7:0]  rd_addr;
  logic        ram_load;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;

  logic        any_strobe;
  logic        busy;

  // Only the address, read flag and write-data fields of jdo matter here.
  logic        unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign busy       = pend_q | (state_q == ST_DBG_RD);
  assign rd_word    = mem[rd_addr];

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    op_d        = op_q;
    pend_d      = pend_q;
    wdata_d     = wdata_q;
    mon_a_d     = mon_a_q;
    mon_d_d     = mon_d_q;
    ready_d     = ready_q;
    error_d     = error_q;
    cpu_rdata_d = cpu_rdata_q;
    rd_addr     = mon_a_q;
    ram_load    = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = mon_a_q;
    mem_wdata   = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          if (op_q == OP_WRITE) begin
            mem_we  = 1'b1;
            mon_a_d = mon_a_q + 8'd1;
            ready_d = 1'b1;
            pend_d  = 1'b0;
          end else begin
            ram_load = 1'b1;
            state_d  = ST_DBG_RD;
          end
        end else if (cpu_write) begin
          mem_we    = 1'b1;
          mem_waddr = cpu_address;
          mem_wdata = cpu_writedata;
        end else if (cpu_read) begin
          // The CPU read data is registered on entry so it is valid in CPU_RD.
          rd_addr     = cpu_address;
          cpu_rdata_d = rd_word;
          state_d     = ST_CPU_RD;
        end
      end
      ST_DBG_RD: begin
        mon_d_d = ram_q;
        mon_a_d = mon_a_q + 8'd1;
        ready_d = 1'b1;
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_CPU_RD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Capture never coincides with debug FSM work: both are gated by busy.
    if (any_strobe) begin
      if (busy) begin
        error_d = 1'b1;
      end else begin
        ready_d = 1'b0;
        pend_d  = 1'b1;
        if (take_action_ocimem_b) begin
          op_d    = OP_WRITE;
          wdata_d = jdo[34:3];
        end else if (take_action_ocimem_a) begin
          mon_a_d = jdo[25:18];
          error_d = 1'b0;
          op_d    = OP_READ;
          if (!jdo[17]) begin
            pend_d  = 1'b0;
            ready_d = 1'b1;
          end
        end else begin
          op_d = OP_READ;
        end
      end
    end
  end

  // CPU_RD is the read completion cycle, so only a write is held off there.
  assign cpu_waitrequest = (cpu_read | cpu_write) &
                           (pend_q | (state_q == ST_DBG_RD) |
                            (cpu_read & (state_q == ST_IDLE)) |
                            (cpu_write & (state_q == ST_CPU_RD)));

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      pend_q      <= 1'b0;
      wdata_q     <= '0;
      mon_a_q     <= '0;
      mon_d_q     <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pend_q      <= pend_d;
      wdata_q     <= wdata_d;
      mon_a_q     <= mon_a_d;
      mon_d_q     <= mon_d_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  // NOTE: the RAM array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (ram_load) begin
      ram_q <= rd_word;
    end
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign cpu_readdata  = cpu_rdata_q;

endmodule
